// File: rtl/nibble_serial_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for the nibble-serial adder.
// NSA_SUBTRACT_EN adds the sub request bit.
interface nibble_serial_adder_ctrl_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NSA_SUBTRACT_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef NSA_SUBTRACT_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built by time-sharing one 4-bit slice, LSB nibble first.
// Optional NSA_SUBTRACT_EN: sub=1 computes a - b (cout=1 means no borrow).
module fourbit_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'd0, c_i};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  nibble_serial_adder_ctrl_if.slave   bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d, sum_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       s_nib;
  logic             c_nib;
  logic             accept, last;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;

  assign accept = (state_q != RUN) && bus.start;
  assign last   = (cnt_q == CW'(NIB - 1));

`ifdef NSA_SUBTRACT_EN
  assign b_cap = bus.sub ? ~bus.b : bus.b;
  assign c_cap = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_cap = bus.b;
  assign c_cap = bus.cin;
`endif

  fourbit_adder u_slice (
    .a_i (a_q[3:0]),
    .b_i (b_q[3:0]),
    .c_i (carry_q),
    .s_o (s_nib),
    .c_o (c_nib)
  );

  // Each new nibble enters at the top, so after NIB shifts nibble 0 sits at the bottom.
  generate
    if (WIDTH > 4) begin : g_wide
      assign res_d = {s_nib, res_q[WIDTH-1:4]};
    end else begin : g_narrow
      assign res_d = s_nib;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.sum  = sum_q;
    bus.cout = cout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= b_cap;
      carry_q <= c_cap;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 4;
      b_q     <= b_q >> 4;
      res_q   <= res_d;
      carry_q <= c_nib;
      cnt_q   <= cnt_q + CW'(1);
      // Results become visible only on the final nibble, so sum holds until then.
      if (last) begin
        sum_q  <= res_d;
        cout_q <= c_nib;
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;
`ifdef NSA_SUBTRACT_EN
  logic sub_v = 1'b0;
`endif

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
`ifdef NSA_SUBTRACT_EN
    if (sub_v) return {1'b0, x} + {1'b0, ~y} + 17'd1;
`endif
    return {1'b0, x} + {1'b0, y} + {16'd0, ci};
  endfunction

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       output int lat, output int nbusy, output logic [W-1:0] s, output logic c);
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.cin = cv;
`ifdef NSA_SUBTRACT_EN
    bus.sub = sub_v;
`endif
    lat = 0; nbusy = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (k == 1) begin
        bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
`ifdef NSA_SUBTRACT_EN
        bus.sub = 1'($urandom);
`endif
      end
      if (bus.done) begin lat = k; break; end
    end
    s = bus.sum; c = bus.cout;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    vectors++; if (bus.sum !== 16'h0) begin errors++; $display("FAIL reset_sum got %h want 0000", bus.sum); end
    vectors++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", bus.cout); end
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_directed();
    logic [W-1:0] av[3] = '{16'h1234, 16'hFFFF, 16'h0000};
    logic [W-1:0] bv[3] = '{16'h4321, 16'h0001, 16'h0000};
    logic         cv[3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] es[3] = '{16'h5555, 16'h0000, 16'h0001};
    logic         ec[3] = '{1'b0, 1'b1, 1'b0};
    int lat, nb; logic [W-1:0] s; logic c;
    for (int i = 0; i < 3; i++) begin
      do_op(av[i], bv[i], cv[i], lat, nb, s, c);
      vectors++; if (lat != NIB + 1) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, NIB + 1); end
      vectors++; if (nb != NIB) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, nb, NIB); end
      vectors++; if (s !== es[i]) begin errors++; $display("FAIL dir%0d_sum got %h want %h", i, s, es[i]); end
      vectors++; if (c !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got %b want %b", i, c, ec[i]); end
    end
  endtask

  task automatic test_random();
    int lat, nb; logic [W-1:0] s, av, bv; logic c, cv; logic [W:0] e;
    for (int i = 0; i < 30; i++) begin
      av = 16'($urandom); bv = 16'($urandom); cv = 1'($urandom);
      if (i % 5 == 0) bv = ~av;
      e = model(av, bv, cv);
      do_op(av, bv, cv, lat, nb, s, c);
      vectors++;
      if (lat != NIB + 1 || s !== e[W-1:0] || c !== e[W])
        begin errors++; $display("FAIL rand%0d got lat=%0d sum=%h cout=%b want lat=%0d sum=%h cout=%b", i, lat, s, c, NIB + 1, e[W-1:0], e[W]); end
    end
  endtask

  // Start is held high throughout; operands churn every cycle and only the
  // values present at an accepting edge may influence a result.
  task automatic test_back_to_back();
    logic [W:0] pend[$];
    logic [W-1:0] av, bv; logic cv; logic [W:0] e;
    int since = 0, got = 0;
    @(negedge clk);
    av = 16'($urandom); bv = 16'($urandom); cv = 1'($urandom);
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.cin = cv;
    pend.push_back(model(av, bv, cv));
    for (int k = 0; k < 60 && got < 4; k++) begin
      @(negedge clk);
      since++;
      av = 16'($urandom); bv = 16'($urandom); cv = 1'($urandom);
      bus.a = av; bus.b = bv; bus.cin = cv;
      if (bus.done) begin
        e = pend.pop_front();
        got++;
        vectors++; if (since != NIB + 1) begin errors++; $display("FAIL b2b%0d_spacing got %0d want %0d", got, since, NIB + 1); end
        vectors++; if ({bus.cout, bus.sum} !== e) begin errors++; $display("FAIL b2b%0d_result got %b_%h want %b_%h", got, bus.cout, bus.sum, e[W], e[W-1:0]); end
        since = 0;
        if (got < 4) pend.push_back(model(av, bv, cv));
        else bus.start = 1'b0;
      end
    end
    vectors++; if (got != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", got); end
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_reset_mid();
    int lat, nb, seen; logic [W-1:0] s; logic c;
    do_op(16'h1234, 16'h4321, 1'b0, lat, nb, s, c);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0F0F; bus.b = 16'h0101; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_flags got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    vectors++; if (bus.sum !== 16'h0 || bus.cout !== 1'b0) begin errors++; $display("FAIL rstmid_result got %b_%h want 0_0000", bus.cout, bus.sum); end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    vectors++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done got %0d active cycles want 0", seen); end
    do_op(16'h0F0F, 16'h0101, 1'b1, lat, nb, s, c);
    vectors++; if (lat != NIB + 1 || s !== 16'h1011 || c !== 1'b0)
      begin errors++; $display("FAIL rstmid_after got lat=%0d %b_%h want lat=%0d 0_1011", lat, c, s, NIB + 1); end
  endtask

  task automatic test_idle_hold();
    int lat, nb; logic [W-1:0] s; logic c;
    do_op(16'h1234, 16'h4321, 1'b0, lat, nb, s, c);
    vectors++; if (s !== 16'h5555) begin errors++; $display("FAIL hold_setup got %h want 5555", s); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
      vectors++;
      if (bus.sum !== 16'h5555 || bus.cout !== 1'b0 || bus.done !== 1'b0)
        begin errors++; $display("FAIL hold%0d got sum=%h cout=%b done=%b want 5555 0 0", k, bus.sum, bus.cout, bus.done); end
    end
  endtask

`ifdef NSA_SUBTRACT_EN
  task automatic test_subtract();
    int lat, nb; logic [W-1:0] s, av, bv; logic c; logic [W:0] e;
    sub_v = 1'b1;
    do_op(16'h0005, 16'h0007, 1'b0, lat, nb, s, c);
    vectors++; if (s !== 16'hFFFE || c !== 1'b0) begin errors++; $display("FAIL sub_5m7 got %b_%h want 0_fffe", c, s); end
    do_op(16'h0007, 16'h0005, 1'b1, lat, nb, s, c);
    vectors++; if (s !== 16'h0002 || c !== 1'b1) begin errors++; $display("FAIL sub_7m5 got %b_%h want 1_0002", c, s); end
    for (int i = 0; i < 10; i++) begin
      sub_v = 1'($urandom);
      av = 16'($urandom); bv = 16'($urandom);
      e = model(av, bv, 1'b1);
      do_op(av, bv, 1'b1, lat, nb, s, c);
      vectors++; if ({c, s} !== e) begin errors++; $display("FAIL subrand%0d got %b_%h want %b_%h", i, c, s, e[W], e[W-1:0]); end
    end
    sub_v = 1'b0;
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
`ifdef NSA_SUBTRACT_EN
    bus.sub = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_idle_hold();
`ifdef NSA_SUBTRACT_EN
    test_subtract();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
